// File: rtl/yx_soe_ctrl.sv
// Sequence-of-events capture for the debounced YX word: change records into a FIFO, read-pop handshake, level irq.
// Optional millisecond timestamp in each record when YX_SOE_TIMESTAMP_EN is defined.
module yx_soe_ctrl #(
    parameter int YX_WIDTH = 4,
    parameter int FIFO_AW  = 3,
    parameter int TICK_DIV = 1000,
    parameter int TS_WIDTH = 16,
`ifdef YX_SOE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_WIDTH + 2*YX_WIDTH
`else
    localparam int ENTRY_W = 2*YX_WIDTH
`endif
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [YX_WIDTH-1:0] yx_state,
    input  logic                rd_req,
    input  logic                clr_ovf,
    output logic [ENTRY_W-1:0]  rd_data,
    output logic                rd_valid,
    output logic [FIFO_AW:0]    fifo_cnt,
    output logic                ovf,
    output logic                irq_out
);

    // state   | meaning
    // ST_INIT | first cycle after reset, snapshot yx_state, no event
    // ST_RUN  | detect changes and capture records
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    logic [0:0]          state_q, state_d;
    logic [YX_WIDTH-1:0] prev_q, prev_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    cnt_q, cnt_d;
    logic [ENTRY_W-1:0]  rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                ovf_q, ovf_d;
    logic                irq_q, irq_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic [YX_WIDTH-1:0] mask;
    logic [ENTRY_W-1:0]  wr_rec;
    logic                evt, pop, push, drop;

`ifdef YX_SOE_TIMESTAMP_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]       PRESC_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [TS_WIDTH-1:0] TS_ONE    = {{(TS_WIDTH-1){1'b0}}, 1'b1};

    logic [PW-1:0]       presc_q, presc_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        ts_d    = ts_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            ts_d    = ts_q + TS_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            presc_q <= '0;
            ts_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
        end
    end

    assign wr_rec = {ts_q, mask, yx_state};
`else
    assign wr_rec = {mask, yx_state};
`endif

    assign mask = yx_state ^ prev_q;
    assign evt  = (state_q == ST_RUN) && (mask != '0);
    assign pop  = rd_req && (cnt_q != '0);
    // a pop in the same cycle frees the slot, so a full FIFO only drops without one
    assign push = evt && ((cnt_q != CNT_FULL) || pop);
    assign drop = evt && !push;

    always_comb begin
        state_d    = ST_RUN;
        prev_d     = prev_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        ovf_d      = ovf_q;

        if (state_q == ST_INIT || evt)
            prev_d = yx_state;

        if (push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (clr_ovf)
            ovf_d = 1'b0;
        if (drop)
            ovf_d = 1'b1;

        irq_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_INIT;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_rec;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign fifo_cnt = cnt_q;
    assign ovf      = ovf_q;
    assign irq_out  = irq_q;

endmodule

// File: tb/tb_yx_soe_ctrl.sv
// Directed bench for yx_soe_ctrl: reset, capture/pop, overflow, full/empty simultaneity, reset mid-run.
// Record timestamp field is checked when YX_SOE_TIMESTAMP_EN is defined.
module tb_yx_soe_ctrl;

`ifdef YX_SOE_TIMESTAMP_EN
    localparam int EW = 24;
`else
    localparam int EW = 8;
`endif

    logic          clk_in = 1'b0;
    logic          rst;
    logic [3:0]    yx_state;
    logic          rd_req;
    logic          clr_ovf;
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [3:0]    fifo_cnt;
    logic          ovf;
    logic          irq_out;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_rec [9];
    logic [EW-1:0] last_rec;

    yx_soe_ctrl dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .yx_state (yx_state),
        .rd_req   (rd_req),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .irq_out  (irq_out)
    );

    always #500 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // all records after the 5 ms wait land in the ts=5 window
    function automatic logic [EW-1:0] mk(input logic [3:0] m, input logic [3:0] s);
`ifdef YX_SOE_TIMESTAMP_EN
        return {16'd5, m, s};
`else
        return {m, s};
`endif
    endfunction

    initial begin
        rst      = 1'b1;
        yx_state = 4'b0101;
        rd_req   = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) tick();
        check("rst_rd_data",  32'(rd_data),  32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_cnt",      32'(fifo_cnt), 32'h0);
        check("rst_ovf",      32'(ovf),      32'h0);
        check("rst_irq",      32'(irq_out),  32'h0);

        // test 1: release, no record for the initial state
        rst = 1'b0;
        tick();
        tick();
        check("t1_cnt", 32'(fifo_cnt), 32'h0);
        check("t1_irq", 32'(irq_out),  32'h0);

        // test 2: single change, read back
`ifdef YX_SOE_TIMESTAMP_EN
        repeat (5500) tick();
`endif
        yx_state = 4'b0111;
        tick();
        check("t2_cnt_after_evt", 32'(fifo_cnt), 32'h1);
        check("t2_irq_rise",      32'(irq_out),  32'h1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
`ifdef YX_SOE_TIMESTAMP_EN
        check("t2_rd_data", 32'(rd_data), 32'h0005_2_7);
`else
        check("t2_rd_data", 32'(rd_data), 32'h27);
`endif
        check("t2_rd_valid", 32'(rd_valid), 32'h1);
        check("t2_cnt_pop",  32'(fifo_cnt), 32'h0);
        check("t2_irq_fall", 32'(irq_out),  32'h0);
        tick();
        check("t2_valid_once", 32'(rd_valid), 32'h0);
        check("t2_data_hold",  32'(rd_data),  32'(mk(4'b0010, 4'b0111)));

        // test 3: nine toggles, ninth dropped
        for (int i = 0; i < 9; i++) begin
            yx_state = yx_state ^ (4'b0001 << (i % 4));
            if (i < 8)
                exp_rec[i] = mk(4'b0001 << (i % 4), yx_state);
            tick();
        end
        check("t3_cnt_full", 32'(fifo_cnt), 32'h8);
        check("t3_ovf_set",  32'(ovf),      32'h1);
        check("t3_irq",      32'(irq_out),  32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'h0);

        // test 4: change plus pop while full
        yx_state = yx_state ^ 4'b0001;
        exp_rec[8] = mk(4'b0001, yx_state);
        rd_req = 1'b1;
        tick();
        check("t4_cnt_stays", 32'(fifo_cnt), 32'h8);
        check("t4_no_ovf",    32'(ovf),      32'h0);
        check("t4_valid",     32'(rd_valid), 32'h1);
        check("t4_rec0",      32'(rd_data),  32'(exp_rec[0]));
        for (int k = 1; k < 9; k++) begin
            tick();
            check($sformatf("t4_rec%0d", k), 32'(rd_data), 32'(exp_rec[k]));
            check($sformatf("t4_valid%0d", k), 32'(rd_valid), 32'h1);
        end
        rd_req = 1'b0;
        check("t4_cnt_empty", 32'(fifo_cnt), 32'h0);
        check("t4_irq_low",   32'(irq_out),  32'h0);
        last_rec = exp_rec[8];

        // test 5: pop on empty, then toggle with pop on empty
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_no_valid", 32'(rd_valid), 32'h0);
        check("t5_data_held", 32'(rd_data), 32'(last_rec));
        yx_state = yx_state ^ 4'b0010;
        rd_req   = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_cnt_one",    32'(fifo_cnt), 32'h1);
        check("t5_no_fallthr", 32'(rd_valid), 32'h0);
        check("t5_data_held2", 32'(rd_data),  32'(last_rec));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_pop_data", 32'(rd_data), 32'(mk(4'b0010, yx_state)));

        // test 6: reset with three records held, then drop + clr_ovf priority not needed
        for (int i = 0; i < 3; i++) begin
            yx_state = yx_state ^ 4'b1000;
            tick();
        end
        check("t6_cnt_three", 32'(fifo_cnt), 32'h3);
        rst = 1'b1;
        tick();
        check("t6_rst_cnt",  32'(fifo_cnt), 32'h0);
        check("t6_rst_ovf",  32'(ovf),      32'h0);
        check("t6_rst_irq",  32'(irq_out),  32'h0);
        check("t6_rst_data", 32'(rd_data),  32'h0);
        rst      = 1'b0;
        yx_state = 4'b1010;
        tick();
        tick();
        tick();
        check("t6_no_rst_evt", 32'(fifo_cnt), 32'h0);

        // overflow set wins over clear in the same cycle
        for (int i = 0; i < 8; i++) begin
            yx_state = yx_state ^ 4'b0100;
            tick();
        end
        yx_state = yx_state ^ 4'b0100;
        clr_ovf  = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(ovf),      32'h1);
        check("ovf_cnt_full", 32'(fifo_cnt), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
